// File: rtl/parity_sweep_ctrl.sv
// Sweeps every N-bit vector into a parity datapath, waits SETTLE cycles, and
// checks the SOP/POS outputs against golden odd parity.
module parity_sweep_ctrl #(
   parameter int unsigned N      = 3,
   parameter int unsigned SETTLE = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   output logic [N-1:0] vec_out,
   input  logic         y_in,
   input  logic         z_in,
   output logic         busy,
   output logic         done,
   output logic         pass,
   output logic [N:0]   mismatch_count,
   output logic [N-1:0] first_fail_vec,
   output logic         first_fail_valid
);

   localparam int unsigned CW = 4;
   localparam logic [N-1:0] VEC_LAST = {N{1'b1}};

   typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;

   state_t        state;
   logic [CW-1:0] settle_cnt;

   logic          exp_c;
   logic          fail_c;
   logic [N:0]    count_nxt_c;

   // Golden check of the vector currently held on the datapath
   assign exp_c       = ^vec_out;
   assign fail_c      = (y_in != exp_c) || (z_in != exp_c);
   assign count_nxt_c = mismatch_count + (N+1)'(fail_c);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         settle_cnt       <= '0;
         vec_out          <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
         pass             <= 1'b0;
         mismatch_count   <= '0;
         first_fail_vec   <= '0;
         first_fail_valid <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  mismatch_count   <= '0;
                  pass             <= 1'b0;
                  first_fail_valid <= 1'b0;
                  first_fail_vec   <= '0;
                  vec_out          <= '0;
                  settle_cnt       <= CW'(SETTLE);
                  busy             <= 1'b1;
                  state            <= (SETTLE == 0) ? SAMPLE : WAIT;
               end
            end
            WAIT: begin
               settle_cnt <= settle_cnt - CW'(1);
               if (settle_cnt <= CW'(1)) state <= SAMPLE;
            end
            SAMPLE: begin
               mismatch_count <= count_nxt_c;
               if (fail_c && !first_fail_valid) begin
                  first_fail_vec   <= vec_out;
                  first_fail_valid <= 1'b1;
               end
               // Sweep stops at all-ones; vec_out is held there afterwards
               if (vec_out == VEC_LAST) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (count_nxt_c == '0);
                  state <= DONE;
               end else begin
                  vec_out    <= vec_out + N'(1);
                  settle_cnt <= CW'(SETTLE);
                  state      <= (SETTLE == 0) ? SAMPLE : WAIT;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_parity_sweep_ctrl.sv
// Directed bench for parity_sweep_ctrl: SETTLE=1 and SETTLE=0 instances
// driven by a parity datapath model with selectable faults.
module tb_parity_sweep_ctrl;

   localparam int unsigned N = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start1 = 1'b0;
   logic start0 = 1'b0;
   int   mode = 0;   // 0 correct, 1 y stuck at 0, 2 z inverted

   logic [N-1:0] vec1, vec0, ffv1, ffv0;
   logic [N:0]   cnt1, cnt0;
   logic         busy1, done1, pass1, ffval1, y1, z1;
   logic         busy0, done0, pass0, ffval0, y0, z0;

   int errors = 0;
   int checks = 0;
   int done_cnt1 = 0;
   int done_cnt0 = 0;

   always #5 clk = ~clk;

   assign y1 = (mode == 1) ? 1'b0 : ^vec1;
   assign z1 = (mode == 2) ? ~(^vec1) : ^vec1;
   assign y0 = (mode == 1) ? 1'b0 : ^vec0;
   assign z0 = (mode == 2) ? ~(^vec0) : ^vec0;

   parity_sweep_ctrl #(.N(N), .SETTLE(1)) dut (
      .clk(clk), .rst_n(rst_n), .start(start1), .vec_out(vec1),
      .y_in(y1), .z_in(z1), .busy(busy1), .done(done1), .pass(pass1),
      .mismatch_count(cnt1), .first_fail_vec(ffv1), .first_fail_valid(ffval1)
   );

   parity_sweep_ctrl #(.N(N), .SETTLE(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .vec_out(vec0),
      .y_in(y0), .z_in(z0), .busy(busy0), .done(done0), .pass(pass0),
      .mismatch_count(cnt0), .first_fail_vec(ffv0), .first_fail_valid(ffval0)
   );

   always @(negedge clk) begin
      if (done1) done_cnt1 <= done_cnt1 + 1;
      if (done0) done_cnt0 <= done_cnt0 + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_results1(input string tag, input int cnt, input int ffv,
                                 input int ffval, input int ps);
      check({tag, " count"}, 32'(cnt1), 32'(cnt));
      check({tag, " first_fail_vec"}, 32'(ffv1), 32'(ffv));
      check({tag, " first_fail_valid"}, 32'(ffval1), 32'(ffval));
      check({tag, " pass"}, 32'(pass1), 32'(ps));
   endtask

   // SETTLE=1 sweep; optionally re-pulse start at vec 3 or reset at vec 4
   task automatic sweep1(input string tag, input bit repulse, input bit abort_mid);
      int d0;
      d0 = done_cnt1;
      @(negedge clk) start1 = 1'b1;
      @(posedge clk) #1 start1 = 1'b0;
      for (int c = 0; c < 16; c++) begin
         check({tag, " busy"}, 32'(busy1), 32'd1);
         check({tag, " vec_out"}, 32'(vec1), 32'(c / 2));
         check({tag, " done low"}, 32'(done1), 32'd0);
         if (repulse && c == 6) start1 = 1'b1;
         if (repulse && c == 7) start1 = 1'b0;
         if (abort_mid && c == 8) begin
            rst_n = 1'b0;
            #1;
            check({tag, " rst vec_out"}, 32'(vec1), 32'd0);
            check({tag, " rst busy"}, 32'(busy1), 32'd0);
            check({tag, " rst done"}, 32'(done1), 32'd0);
            check({tag, " rst pass"}, 32'(pass1), 32'd0);
            check({tag, " rst count"}, 32'(cnt1), 32'd0);
            check({tag, " rst ffv"}, 32'(ffv1), 32'd0);
            check({tag, " rst ffvalid"}, 32'(ffval1), 32'd0);
            @(negedge clk) rst_n = 1'b1;
            repeat (20) @(posedge clk);
            #1 check({tag, " no done after reset"}, 32'(done_cnt1 - d0), 32'd0);
            check({tag, " idle after reset"}, 32'(busy1), 32'd0);
            return;
         end
         @(posedge clk) #1;
      end
      check({tag, " done high"}, 32'(done1), 32'd1);
      check({tag, " busy low at done"}, 32'(busy1), 32'd0);
      check({tag, " vec held"}, 32'(vec1), 32'd7);
      @(posedge clk) #1;
      check({tag, " done one cycle"}, 32'(done1), 32'd0);
      check({tag, " done pulses"}, 32'(done_cnt1 - d0), 32'd1);
      check({tag, " vec still held"}, 32'(vec1), 32'd7);
   endtask

   initial begin
      #1;
      check("reset vec_out", 32'(vec1), 32'd0);
      check("reset busy", 32'(busy1), 32'd0);
      check("reset done", 32'(done1), 32'd0);
      check("reset pass", 32'(pass1), 32'd0);
      check("reset count", 32'(cnt1), 32'd0);
      check("reset ffvalid", 32'(ffval1), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      mode = 0;
      sweep1("good", 1'b0, 1'b0);
      check_results1("good", 0, 0, 0, 1);

      mode = 1;
      sweep1("ystuck", 1'b0, 1'b0);
      check_results1("ystuck", 4, 1, 1, 0);

      mode = 2;
      sweep1("zinv", 1'b0, 1'b0);
      check_results1("zinv", 8, 0, 1, 0);

      mode = 0;
      sweep1("rerun", 1'b0, 1'b0);
      check_results1("rerun", 0, 0, 0, 1);

      mode = 1;
      repeat (3) @(posedge clk);
      #1 check("results held count", 32'(cnt1), 32'd0);

      mode = 0;
      sweep1("repulse", 1'b1, 1'b0);
      check_results1("repulse", 0, 0, 0, 1);
      repeat (4) @(posedge clk);
      #1 check("repulse not queued", 32'(busy1), 32'd0);

      mode = 1;
      sweep1("abort", 1'b0, 1'b1);
      mode = 0;
      sweep1("after abort", 1'b0, 1'b0);
      check_results1("after abort", 0, 0, 0, 1);

      // SETTLE=0 instance: one vector per cycle
      begin
         int d0;
         d0 = done_cnt0;
         @(negedge clk) start0 = 1'b1;
         @(posedge clk) #1 start0 = 1'b0;
         for (int c = 0; c < 8; c++) begin
            check("s0 busy", 32'(busy0), 32'd1);
            check("s0 vec_out", 32'(vec0), 32'(c));
            @(posedge clk) #1;
         end
         check("s0 done high", 32'(done0), 32'd1);
         check("s0 busy low", 32'(busy0), 32'd0);
         check("s0 pass", 32'(pass0), 32'd1);
         check("s0 count", 32'(cnt0), 32'd0);
         check("s0 ffvalid", 32'(ffval0), 32'd0);
         @(posedge clk) #1;
         check("s0 done pulses", 32'(done_cnt0 - d0), 32'd1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
